// File: rtl/rv32i_register_file_pkg.sv
// Shared core constants for the RV32I integer register file.
// Holds the default data/address widths and the hardwired-zero register index.
package rv32i_register_file_pkg;

  localparam int XLEN  = 32;
  localparam int XADDR = 5;
  localparam int X0    = 0;

  function automatic logic is_x0(input logic [XADDR-1:0] addr);
    return addr == XADDR'(X0);
  endfunction

endpackage

// File: rtl/rv32i_register_file_if.sv
// Register-file access bundle.
// Decode/writeback drive it as master; the register file is the slave.
interface rv32i_register_file_if #(
  parameter int XLEN  = rv32i_register_file_pkg::XLEN,
  parameter int XADDR = rv32i_register_file_pkg::XADDR
);

  logic [XADDR-1:0] i_rs1_addr;
  logic [XADDR-1:0] i_rs2_addr;
  logic [XADDR-1:0] i_rd_addr;
  logic [XLEN-1:0]  i_rd_data;
  logic [XLEN-1:0]  or_rs1_data;
  logic [XLEN-1:0]  or_rs2_data;

  modport master (
    output i_rs1_addr, i_rs2_addr, i_rd_addr, i_rd_data,
    input  or_rs1_data, or_rs2_data
  );

  modport slave (
    input  i_rs1_addr, i_rs2_addr, i_rd_addr, i_rd_data,
    output or_rs1_data, or_rs2_data
  );

endinterface

// File: rtl/rv32i_register_file_read_port.sv
// One registered read port: x0 forcing, same-cycle write bypass, array mux.
// Instantiated once per source operand.
module rf_read_port
  import rv32i_register_file_pkg::*;
#(
  parameter int XLEN  = rv32i_register_file_pkg::XLEN,
  parameter int XADDR = rv32i_register_file_pkg::XADDR,
  parameter int NREG  = 1 << XADDR
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [XADDR-1:0]          i_rs_addr,
  input  logic [XADDR-1:0]          i_rd_addr,
  input  logic [XLEN-1:0]           i_rd_data,
  input  logic [NREG-1:0][XLEN-1:0] i_regs,
  output logic [XLEN-1:0]           or_rs_data
);

  logic [XLEN-1:0] data_d;
  logic [XLEN-1:0] data_q;

  // The bypass returns the value being written this edge, so decode never stalls on writeback.
  always_comb begin
    data_d = {XLEN{1'b0}};
    if (i_rs_addr == XADDR'(X0)) begin
      data_d = {XLEN{1'b0}};
    end else if (i_rs_addr == i_rd_addr) begin
      data_d = i_rd_data;
    end else begin
      data_d = i_regs[i_rs_addr];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= {XLEN{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign or_rs_data = data_q;

endmodule

// File: rtl/rv32i_register_file.sv
// RV32I integer register file: 2**XADDR flop-based entries, x0 hardwired to zero,
// two registered read ports with write bypass and one write port.
module rv32i_register_file
  import rv32i_register_file_pkg::*;
#(
  parameter int XLEN  = rv32i_register_file_pkg::XLEN,
  parameter int XADDR = rv32i_register_file_pkg::XADDR
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  rv32i_register_file_if.slave  rf
);

  localparam int NREG = 1 << XADDR;

  logic [NREG-1:0][XLEN-1:0] regs_d;
  logic [NREG-1:0][XLEN-1:0] regs_q;

  // Flops rather than RAM so every entry clears on asynchronous reset; entry 0 stays zero.
  always_comb begin
    regs_d = regs_q;
    if (rf.i_rd_addr != XADDR'(X0)) begin
      regs_d[rf.i_rd_addr] = rf.i_rd_data;
    end else begin
      regs_d = regs_q;
    end
    regs_d[X0] = {XLEN{1'b0}};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_read_port #(.XLEN(XLEN), .XADDR(XADDR), .NREG(NREG)) u_rs1 (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rs_addr  (rf.i_rs1_addr),
    .i_rd_addr  (rf.i_rd_addr),
    .i_rd_data  (rf.i_rd_data),
    .i_regs     (regs_q),
    .or_rs_data (rf.or_rs1_data)
  );

  rf_read_port #(.XLEN(XLEN), .XADDR(XADDR), .NREG(NREG)) u_rs2 (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rs_addr  (rf.i_rs2_addr),
    .i_rd_addr  (rf.i_rd_addr),
    .i_rd_data  (rf.i_rd_data),
    .i_regs     (regs_q),
    .or_rs_data (rf.or_rs2_data)
  );

endmodule

// File: tb/tb_rv32i_register_file.sv
// Directed self-checking bench for rv32i_register_file; expected read data is
// queued when a cycle is driven and compared one edge later.
module tb_rv32i_register_file;

  logic i_clk;
  logic i_rst;
  int   tests_run;
  int   tests_failed;

  logic [31:0] exp1_q[$];
  logic [31:0] exp2_q[$];
  string       tag_q[$];

  rv32i_register_file_if #(.XLEN(32), .XADDR(5)) rf_if ();

  rv32i_register_file #(.XLEN(32), .XADDR(5)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .rf    (rf_if.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] fill_val(input int idx);
    logic [31:0] v;
    v = 32'(idx) * 32'h0101_0101;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, queue its expected read data, then compare just after the edge.
  task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] data,
                      input logic [31:0] e1, input logic [31:0] e2);
    logic [31:0] x1;
    logic [31:0] x2;
    string       t;
    rf_if.i_rs1_addr = rs1;
    rf_if.i_rs2_addr = rs2;
    rf_if.i_rd_addr  = rd;
    rf_if.i_rd_data  = data;
    exp1_q.push_back(e1);
    exp2_q.push_back(e2);
    tag_q.push_back(tag);
    @(posedge i_clk);
    #1;
    x1 = exp1_q.pop_front();
    x2 = exp2_q.pop_front();
    t  = tag_q.pop_front();
    check({t, "_rs1"}, rf_if.or_rs1_data, x1);
    check({t, "_rs2"}, rf_if.or_rs2_data, x2);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Reset held with random traffic on the bus.
    i_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rf_if.i_rs1_addr = 5'($urandom_range(31, 0));
      rf_if.i_rs2_addr = 5'($urandom_range(31, 0));
      rf_if.i_rd_addr  = 5'($urandom_range(31, 1));
      rf_if.i_rd_data  = 32'($urandom);
      @(posedge i_clk);
      #1;
      check("reset_hold_rs1", rf_if.or_rs1_data, 32'h0000_0000);
      check("reset_hold_rs2", rf_if.or_rs2_data, 32'h0000_0000);
    end
    rf_if.i_rd_addr = 5'd0;
    i_rst = 1'b0;

    for (int i = 1; i < 32; i++)
      step("post_reset", 5'(i), 5'(i), 5'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000);

    step("wr_x5",    5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000);
    step("rd_x5",    5'd5, 5'd5, 5'd0, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    step("wr_x0",    5'd0, 5'd5, 5'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hDEAD_BEEF);
    step("rd_x0",    5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000);

    step("wr_x8",    5'd0, 5'd0, 5'd8, 32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_0000);
    step("bypass7",  5'd7, 5'd8, 5'd7, 32'h1234_5678, 32'h1234_5678, 32'hA5A5_A5A5);
    step("rd_x7",    5'd8, 5'd7, 5'd0, 32'h0000_0000, 32'hA5A5_A5A5, 32'h1234_5678);
    step("dual_byp", 5'd9, 5'd9, 5'd9, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D);
    step("b2b_1",    5'd9, 5'd0, 5'd9, 32'h1111_1111, 32'h1111_1111, 32'h0000_0000);
    step("b2b_2",    5'd9, 5'd9, 5'd9, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222);
    step("b2b_last", 5'd9, 5'd5, 5'd0, 32'h0000_0000, 32'h2222_2222, 32'hDEAD_BEEF);

    for (int i = 1; i < 32; i++)
      step("fill_wr", 5'd0, 5'd0, 5'(i), fill_val(i), 32'h0000_0000, 32'h0000_0000);
    for (int i = 0; i < 32; i++)
      step("fill_rd", 5'(i), 5'(31 - i), 5'd0, 32'h0000_0000,
           (i == 0) ? 32'h0000_0000 : fill_val(i),
           (i == 31) ? 32'h0000_0000 : fill_val(31 - i));

    // Reset between edges, with a write to x3 pending on the coincident edge.
    rf_if.i_rs1_addr = 5'd31;
    rf_if.i_rs2_addr = 5'd30;
    rf_if.i_rd_addr  = 5'd3;
    rf_if.i_rd_data  = 32'hFFFF_FFFF;
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_rs1", rf_if.or_rs1_data, 32'h0000_0000);
    check("async_rst_rs2", rf_if.or_rs2_data, 32'h0000_0000);
    @(posedge i_clk);
    #1;
    check("rst_edge_rs1", rf_if.or_rs1_data, 32'h0000_0000);
    rf_if.i_rd_addr = 5'd0;
    i_rst = 1'b0;

    for (int i = 1; i < 32; i++)
      step("after_rst", 5'(i), 5'(32 - i), 5'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
